// File: rtl/ram_arb_if.sv
// Word-addressed stb/we/ack memory port shared by the arbiter's requesters and its RAM side.
interface ram_arb_if;
  logic        stb;
  logic        we;
  logic [21:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output stb, we, addr, wdata, input rdata, ack);
  modport slave  (input stb, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/ram_arb.sv
// Three-port arbiter in front of a single-port RAM: one latched access at a time,
// completed with a one-cycle ack to the port that won it.
module ram_arb #(
  parameter bit PRIO0 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  ram_arb_if.slave   m0,
  ram_arb_if.slave   m1,
  ram_arb_if.slave   m2,
  ram_arb_if.master  ram,
  output logic [1:0] grant,
  output logic       busy
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant_nxt, last, win;
  logic [2:0]  req;
  logic        hold_we, sel_we;
  logic [21:0] hold_addr, sel_addr;
  logic [31:0] hold_wdata, sel_wdata;
  logic        done;

  assign req = {m2.stb, m1.stb, m0.stb};

  // Winner is only meaningful when some request is up; rotation starts after last.
  always_comb begin
    win = 2'd0;
    if (PRIO0) begin
      if (req[0])           win = 2'd0;
      else if (last == 2'd1) win = req[2] ? 2'd2 : 2'd1;
      else                  win = req[1] ? 2'd1 : 2'd2;
    end else begin
      case (last)
        2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  always_comb begin
    sel_we    = m0.we;
    sel_addr  = m0.addr;
    sel_wdata = m0.wdata;
    case (win)
      2'd1: begin sel_we = m1.we; sel_addr = m1.addr; sel_wdata = m1.wdata; end
      2'd2: begin sel_we = m2.we; sel_addr = m2.addr; sel_wdata = m2.wdata; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: if (|req) begin
        state_nxt = BUSY;
        grant_nxt = win;
      end
      BUSY: if (ram.ack) begin
        state_nxt = IDLE;
        grant_nxt = 2'd3;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'd3;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 2'd3;
      last       <= 2'd2;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == IDLE && |req) begin
        last       <= win;
        hold_we    <= sel_we;
        hold_addr  <= sel_addr;
        hold_wdata <= sel_wdata;
      end
    end
  end

  // Strobe comes straight from the state register, so it falls on the ack edge.
  assign busy      = (state == BUSY);
  assign ram.stb   = busy;
  assign ram.we    = hold_we;
  assign ram.addr  = hold_addr;
  assign ram.wdata = hold_wdata;

  assign done     = busy && ram.ack;
  assign m0.ack   = done && (grant == 2'd0);
  assign m1.ack   = done && (grant == 2'd1);
  assign m2.ack   = done && (grant == 2'd2);
  assign m0.rdata = ram.rdata;
  assign m1.rdata = ram.rdata;
  assign m2.rdata = ram.rdata;
endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: one fixed-priority instance with a variable-latency RAM
// model, one full round-robin instance with a two-cycle RAM.
module tb_ram_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ram_arb_if pa0(), pa1(), pa2(), ra();
  ram_arb_if pb0(), pb1(), pb2(), rb();
  logic [1:0] grant_a, grant_b;
  logic       busy_a, busy_b;

  ram_arb #(.PRIO0(1'b1)) dut_a (.clk(clk), .rst(rst), .m0(pa0), .m1(pa1), .m2(pa2),
                                 .ram(ra), .grant(grant_a), .busy(busy_a));
  ram_arb #(.PRIO0(1'b0)) dut_b (.clk(clk), .rst(rst), .m0(pb0), .m1(pb1), .m2(pb2),
                                 .ram(rb), .grant(grant_b), .busy(busy_b));

  // RAM model A: ack lands in the lat-th strobe cycle; also watches for unstable
  // holding values and a strobe in the cycle right after an ack.
  logic [31:0] mem [logic [21:0]];
  int          rd_lat = 2, wr_lat = 2, cnt_a = 0, unstable = 0, spurious = 0;
  logic        had_ack = 1'b0, cap_we = 1'b0;
  logic [21:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;

  always @(posedge clk) begin
    if (!rst) begin
      ra.ack  <= 1'b0;
      cnt_a   <= 0;
      had_ack <= 1'b0;
    end else begin
      had_ack <= ra.ack;
      if (had_ack && ra.stb) spurious++;
      if (ra.ack) begin
        ra.ack <= 1'b0;
        cnt_a  <= 0;
      end else if (ra.stb) begin
        if (cnt_a == 0) begin
          cap_we <= ra.we; cap_addr <= ra.addr; cap_wdata <= ra.wdata;
        end else if (ra.we !== cap_we || ra.addr !== cap_addr || ra.wdata !== cap_wdata)
          unstable++;
        if (cnt_a + 2 >= (ra.we ? wr_lat : rd_lat)) begin
          ra.ack <= 1'b1;
          if (ra.we) mem[ra.addr] = ra.wdata;
          ra.rdata <= mem.exists(ra.addr) ? mem[ra.addr] : 32'h0;
        end
        cnt_a <= cnt_a + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) rb.ack <= 1'b0;
    else      rb.ack <= rb.stb && !rb.ack;
  end
  assign rb.rdata = 32'hB0B0_B0B0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int p, input logic s, input logic w,
                       input logic [21:0] a, input logic [31:0] d);
    case (p)
      0: begin pa0.stb = s; pa0.we = w; pa0.addr = a; pa0.wdata = d; end
      1: begin pa1.stb = s; pa1.we = w; pa1.addr = a; pa1.wdata = d; end
      default: begin pa2.stb = s; pa2.we = w; pa2.addr = a; pa2.wdata = d; end
    endcase
  endtask

  task automatic set_b(input int p, input logic s);
    case (p)
      0: begin pb0.stb = s; pb0.we = 1'b0; pb0.addr = 22'd0; pb0.wdata = '0; end
      1: begin pb1.stb = s; pb1.we = 1'b0; pb1.addr = 22'd1; pb1.wdata = '0; end
      default: begin pb2.stb = s; pb2.we = 1'b0; pb2.addr = 22'd2; pb2.wdata = '0; end
    endcase
  endtask

  function automatic logic ack_a(input int p);
    case (p)
      0: return pa0.ack;
      1: return pa1.ack;
      default: return pa2.ack;
    endcase
  endfunction

  // One complete access on instance A; returns read data and strobe-high cycles up to ack.
  task automatic access_a(input int p, input logic w, input logic [21:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int n);
    logic got;
    got = 1'b0; n = 0; rd = '0;
    @(negedge clk);
    set_a(p, 1'b1, w, a, d);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ra.stb) n++;
      if (ack_a(p)) begin got = 1'b1; rd = ra.rdata; end
    end
    set_a(p, 1'b0, 1'b0, '0, '0);
    chk($sformatf("ack_seen_p%0d", p), got, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] rd;
    int          n, n0, acks;
    int          seq[$];
    int          exp_a[7] = '{0, 0, 0, 1, 2, 1, 2};
    int          exp_b[6] = '{0, 1, 2, 0, 1, 2};

    for (int p = 0; p < 3; p++) begin set_a(p, 0, 0, '0, '0); set_b(p, 0); end
    mem[22'h10] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", grant_a, 3);
    chk("rst_busy", busy_a, 0);
    chk("rst_ram_stb", ra.stb, 0);
    chk("rst_ram_we", ra.we, 0);
    chk("rst_ram_addr", ra.addr, 0);
    chk("rst_ram_wdata", ra.wdata, 0);
    chk("rst_acks", {pa0.ack, pa1.ack, pa2.ack}, 0);
    chk("rst_grant_b", grant_b, 3);
    rst = 1'b1;

    // Single minimum-latency read on port 1, cycle by cycle
    @(negedge clk);
    set_a(1, 1, 0, 22'h10, '0);
    @(negedge clk);
    chk("t1_grant", grant_a, 1);
    chk("t1_busy", busy_a, 1);
    chk("t1_stb", ra.stb, 1);
    chk("t1_addr", ra.addr, 22'h10);
    chk("t1_no_early_ack", pa1.ack, 0);
    @(negedge clk);
    chk("t1_ack", pa1.ack, 1);
    chk("t1_rdata", pa1.rdata, 32'hDEAD_BEEF);
    chk("t1_other_acks", {pa0.ack, pa2.ack}, 0);
    set_a(1, 0, 0, '0, '0);
    @(negedge clk);
    chk("t1_stb_drop", ra.stb, 0);
    chk("t1_grant_idle", grant_a, 3);
    chk("t1_busy_idle", busy_a, 0);
    chk("t1_ack_once", pa1.ack, 0);

    // Write then read back at the top word on port 2
    access_a(2, 1, 22'h3F_FFFF, 32'h1234_5678, rd, n);
    chk("t2_wr_lat", n, 2);
    access_a(2, 0, 22'h3F_FFFF, '0, rd, n);
    chk("t2_readback", rd, 32'h1234_5678);

    // Fixed priority: port 0 wins while up, then 1/2 alternate
    @(negedge clk);
    set_a(0, 1, 0, 22'd1, '0); set_a(1, 1, 0, 22'd2, '0); set_a(2, 1, 0, 22'd3, '0);
    n0 = 0;
    for (int i = 0; i < 200 && seq.size() < 7; i++) begin
      @(negedge clk);
      if (pa0.ack) begin seq.push_back(0); n0++; if (n0 == 3) set_a(0, 0, 0, '0, '0); end
      if (pa1.ack) seq.push_back(1);
      if (pa2.ack) seq.push_back(2);
    end
    for (int p = 0; p < 3; p++) set_a(p, 0, 0, '0, '0);
    chk("t3_count", seq.size(), 7);
    for (int i = 0; i < 7 && i < seq.size(); i++) chk($sformatf("t3_grant%0d", i), seq[i], exp_a[i]);

    // Full round-robin on instance B, untouched since reset
    seq.delete();
    @(negedge clk);
    for (int p = 0; p < 3; p++) set_b(p, 1);
    for (int i = 0; i < 200 && seq.size() < 6; i++) begin
      @(negedge clk);
      chk("t4_onehot", (pb0.ack + pb1.ack + pb2.ack) <= 1, 1);
      if (pb0.ack) seq.push_back(0);
      if (pb1.ack) seq.push_back(1);
      if (pb2.ack) seq.push_back(2);
    end
    for (int p = 0; p < 3; p++) set_b(p, 0);
    chk("t4_count", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) chk($sformatf("t4_grant%0d", i), seq[i], exp_b[i]);

    // Port 1 drops stb and scrambles its bus mid-write
    wr_lat = 6;
    @(negedge clk);
    set_a(1, 1, 1, 22'h2A, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t5_busy", busy_a, 1);
    set_a(1, 0, 1, 22'h111, 32'h0BAD_0BAD);
    acks = 0;
    repeat (12) begin @(negedge clk); if (pa1.ack) acks++; end
    chk("t5_ack_once", acks, 1);
    chk("t5_mem", mem.exists(22'h2A) ? mem[22'h2A] : 32'h0, 32'hCAFE_F00D);
    chk("t5_no_stray", mem.exists(22'h111), 0);

    // Reset in the middle of a long read
    rd_lat = 14;
    @(negedge clk);
    set_a(2, 1, 0, 22'h10, '0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy", busy_a, 1);
    rst = 1'b0;
    set_a(2, 0, 0, '0, '0);
    @(negedge clk);
    chk("t6_grant", grant_a, 3);
    chk("t6_busy_clr", busy_a, 0);
    chk("t6_stb_clr", ra.stb, 0);
    rst = 1'b1;
    acks = 0;
    repeat (20) begin @(negedge clk); if (pa2.ack) acks++; end
    chk("t6_no_ack", acks, 0);

    // Service resumes; realistic latencies
    access_a(2, 0, 22'h10, '0, rd, n);
    chk("t6_rdata", rd, 32'hDEAD_BEEF);
    chk("t6_rd_lat", n, 14);
    access_a(0, 1, 22'h5, 32'h55AA_55AA, rd, n);
    chk("t6_wr_lat", n, 6);
    chk("t6_wr_mem", mem.exists(22'h5) ? mem[22'h5] : 32'h0, 32'h55AA_55AA);

    repeat (2) @(negedge clk);
    chk("hold_stable", unstable, 0);
    chk("dead_cycle", spurious, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
